// File: rtl/ts_sync_recovery_mc.sv
// N-channel MPEG-2 TS sync recovery: per-channel HUNT/VERIFY/LOCK flywheel
// that finds the sync byte, confirms periodicity and forwards aligned bytes.
//
// state  | meaning
// -------+------------------------------------------------------------
// HUNT   | searching for a sync byte; input bytes dropped
// VERIFY | candidate found; checking sync at each expected position
// LOCK   | aligned; bytes forwarded, misses counted by the flywheel
module ts_sync_recovery_mc #(
    parameter int          N_CH       = 4,
    parameter int          PKT_LEN    = 188,
    parameter logic [7:0]  SYNC_BYTE  = 8'h47,
    parameter int          LOCK_CNT   = 3,
    parameter int          UNLOCK_CNT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8*N_CH-1:0]   byte_in,
    input  logic [N_CH-1:0]     valid_in,
    output logic [8*N_CH-1:0]   byte_out,
    output logic [N_CH-1:0]     valid_out,
    output logic [N_CH-1:0]     sync_out,
    output logic [N_CH-1:0]     locked,
    output logic [N_CH-1:0]     sync_miss,
    output logic [N_CH-1:0]     lock_lost
);

    localparam int PW = $clog2(PKT_LEN);
    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t         state_q, state_d;
        logic [PW-1:0]  pos_q, pos_d, pos_inc;
        logic [HW-1:0]  hits_q, hits_d, hits_inc;
        logic [MW-1:0]  misses_q, misses_d, misses_inc;
        logic [7:0]     byte_q, byte_d, din;
        logic           vout_q, vout_d;
        logic           sync_q, sync_d;
        logic           locked_q, locked_d;
        logic           miss_q, miss_d;
        logic           lost_q, lost_d;
        logic           at_sync, is_sync;

        assign din        = byte_in[8*c +: 8];
        assign is_sync    = (din == SYNC_BYTE);
        assign at_sync    = (pos_q == '0);
        assign pos_inc    = (pos_q == PW'(PKT_LEN - 1)) ? '0 : pos_q + PW'(1);
        assign hits_inc   = hits_q + HW'(1);
        assign misses_inc = misses_q + MW'(1);

        always_comb begin
            state_d  = state_q;
            pos_d    = pos_q;
            hits_d   = hits_q;
            misses_d = misses_q;
            byte_d   = byte_q;
            vout_d   = 1'b0;
            sync_d   = 1'b0;
            miss_d   = 1'b0;
            lost_d   = 1'b0;
            if (valid_in[c]) begin
                case (state_q)
                    ST_HUNT: begin
                        if (is_sync) begin
                            hits_d = HW'(1);
                            pos_d  = PW'(1);
                            if (LOCK_CNT == 1) begin
                                state_d = ST_LOCK;
                                vout_d  = 1'b1;
                                sync_d  = 1'b1;
                                byte_d  = din;
                            end else begin
                                state_d = ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        pos_d = pos_inc;
                        if (at_sync) begin
                            if (is_sync) begin
                                hits_d = hits_inc;
                                // The byte that completes verification is the first one forwarded.
                                if (hits_inc == HW'(LOCK_CNT)) begin
                                    state_d = ST_LOCK;
                                    vout_d  = 1'b1;
                                    sync_d  = 1'b1;
                                    byte_d  = din;
                                end
                            end else begin
                                state_d = ST_HUNT;
                                hits_d  = '0;
                                pos_d   = '0;
                            end
                        end
                    end
                    ST_LOCK: begin
                        pos_d  = pos_inc;
                        vout_d = 1'b1;
                        sync_d = at_sync;
                        byte_d = din;
                        if (at_sync) begin
                            if (is_sync) begin
                                misses_d = '0;
                            end else begin
                                misses_d = misses_inc;
                                miss_d   = 1'b1;
                                if (misses_inc == MW'(UNLOCK_CNT)) begin
                                    state_d  = ST_HUNT;
                                    lost_d   = 1'b1;
                                    vout_d   = 1'b0;
                                    sync_d   = 1'b0;
                                    byte_d   = byte_q;
                                    misses_d = '0;
                                    hits_d   = '0;
                                    pos_d    = '0;
                                end
                            end
                        end
                    end
                    default: begin
                        state_d = ST_HUNT;
                        pos_d   = '0;
                        hits_d  = '0;
                    end
                endcase
            end
            locked_d = (state_d == ST_LOCK);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q  <= ST_HUNT;
                pos_q    <= '0;
                hits_q   <= '0;
                misses_q <= '0;
                byte_q   <= '0;
                vout_q   <= 1'b0;
                sync_q   <= 1'b0;
                locked_q <= 1'b0;
                miss_q   <= 1'b0;
                lost_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                pos_q    <= pos_d;
                hits_q   <= hits_d;
                misses_q <= misses_d;
                byte_q   <= byte_d;
                vout_q   <= vout_d;
                sync_q   <= sync_d;
                locked_q <= locked_d;
                miss_q   <= miss_d;
                lost_q   <= lost_d;
            end
        end

        assign byte_out[8*c +: 8] = byte_q;
        assign valid_out[c]       = vout_q;
        assign sync_out[c]        = sync_q;
        assign locked[c]          = locked_q;
        assign sync_miss[c]       = miss_q;
        assign lock_lost[c]       = lost_q;
    end

endmodule
